// File: rtl/toggle_checker_pkg.sv
// Shared types and constants for the toggle checker: FSM state encoding,
// fault cause codes and the acquisition timeout.
package toggle_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAULT   = 2'd3
    } state_e;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE       = 2'd0;
    localparam err_code_t ERR_MISS_LIMIT = 2'd1;
    localparam err_code_t ERR_ACQ_STUCK  = 2'd2;

    // Cumulative misses tolerated in ACQUIRE before declaring the source stuck.
    localparam int ACQ_TIMEOUT = 16;

endpackage

// File: rtl/toggle_checker_sat.sv
// Saturating up-counter used for the externally visible statistics.
// Latency: 1 cycle; no backpressure; clr wins over inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/toggle_checker.sv
// Monitors a signal that should invert every cycle; acquires lock, detects misses, raises fault events.
// Latency: state/locked/fault 1 cycle after the deciding sample; err_valid one cycle after FAULT entry.
// Backpressure: err_valid holds with a stable err_code until err_ready; FAULT needs clear so no second event can queue.
module toggle_checker
    import toggle_checker_pkg::*;
#(
    parameter int LOCK_CYCLES = 4,
    parameter int MAX_MISS    = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_signal,
    input  logic             enable,
    input  logic             clear,
    output logic             locked,
    output logic             fault,
    output logic [CNT_W-1:0] toggle_count,
    output logic [7:0]       miss_count,
    output logic             err_valid,
    input  logic             err_ready,
    output logic [1:0]       err_code
);

    localparam logic [4:0] LOCK_L = 5'(LOCK_CYCLES);
    localparam logic [4:0] MISS_L = 5'(MAX_MISS);
    localparam logic [4:0] ACQ_L  = 5'(ACQ_TIMEOUT);

    state_e    state_q, state_nxt;
    logic      prev_q;
    logic [4:0] run_q, run_nxt;
    logic [4:0] acq_q, acq_nxt;
    logic [4:0] cmiss_q, cmiss_nxt;
    err_code_t code_q, code_nxt;
    logic      entry_q;
    logic      toggle;
    logic      fault_entry;
    logic      tc_inc;
    logic      mc_inc;

    assign toggle = in_signal ^ prev_q;

    always_comb begin
        state_nxt = state_q;
        run_nxt   = run_q;
        acq_nxt   = acq_q;
        cmiss_nxt = cmiss_q;
        code_nxt  = code_q;
        if (clear) begin
            // Clear outranks every other event this cycle, including a lock or fault decision.
            run_nxt   = '0;
            acq_nxt   = '0;
            cmiss_nxt = '0;
            code_nxt  = ERR_NONE;
            if (state_q == ST_FAULT) begin
                state_nxt = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_nxt = ST_ACQUIRE;
                        run_nxt   = '0;
                        acq_nxt   = '0;
                    end
                end
                ST_ACQUIRE: begin
                    if (!enable) begin
                        state_nxt = ST_IDLE;
                    end else if (toggle) begin
                        run_nxt = run_q + 5'd1;
                        if ((run_q + 5'd1) >= LOCK_L) begin
                            state_nxt = ST_LOCKED;
                            cmiss_nxt = '0;
                        end
                    end else begin
                        run_nxt = '0;
                        acq_nxt = acq_q + 5'd1;
                        if ((acq_q + 5'd1) >= ACQ_L) begin
                            state_nxt = ST_FAULT;
                            code_nxt  = ERR_ACQ_STUCK;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (!enable) begin
                        state_nxt = ST_IDLE;
                    end else if (toggle) begin
                        cmiss_nxt = '0;
                    end else begin
                        cmiss_nxt = cmiss_q + 5'd1;
                        if ((cmiss_q + 5'd1) >= MISS_L) begin
                            state_nxt = ST_FAULT;
                            code_nxt  = ERR_MISS_LIMIT;
                        end
                    end
                end
                ST_FAULT: begin
                    state_nxt = ST_FAULT;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign fault_entry = (state_nxt == ST_FAULT) && (state_q != ST_FAULT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            prev_q  <= 1'b0;
            run_q   <= '0;
            acq_q   <= '0;
            cmiss_q <= '0;
            code_q  <= ERR_NONE;
            entry_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            prev_q  <= in_signal;
            run_q   <= run_nxt;
            acq_q   <= acq_nxt;
            cmiss_q <= cmiss_nxt;
            code_q  <= code_nxt;
            entry_q <= fault_entry;
        end
    end

    // entry_q delays the event by one cycle so err_valid trails the fault flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_valid <= 1'b0;
        end else if (clear) begin
            err_valid <= 1'b0;
        end else if (entry_q) begin
            err_valid <= 1'b1;
        end else if (err_valid && err_ready) begin
            err_valid <= 1'b0;
        end
    end

    assign tc_inc = toggle && enable && ((state_q == ST_ACQUIRE) || (state_q == ST_LOCKED));
    assign mc_inc = !toggle && enable && (state_q == ST_LOCKED);

    sat_counter #(.W(CNT_W)) u_toggle_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (tc_inc),
        .clr   (clear),
        .count (toggle_count)
    );

    sat_counter #(.W(8)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mc_inc),
        .clr   (clear),
        .count (miss_count)
    );

    assign locked   = (state_q == ST_LOCKED);
    assign fault    = (state_q == ST_FAULT);
    assign err_code = code_q;

endmodule
